// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned multiplier retiring DIGIT multiplier bits per clock, valid/ready on both sides.
// Optional: define SEQ_MULT_SQUARE_EN to add the `square` input (b_r loads from a).
module seq_multiplier #(
   parameter int BITWIDTH = 32,
   parameter int DIGIT    = 4
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BITWIDTH-1:0]     a,
   input  logic [BITWIDTH-1:0]     b,
`ifdef SEQ_MULT_SQUARE_EN
   input  logic                    square,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*BITWIDTH-1:0]   y
);

   generate
      if (BITWIDTH < 1 || DIGIT < 1 || DIGIT > BITWIDTH || (BITWIDTH % DIGIT) != 0) begin : g_bad_params
         $error("seq_multiplier: illegal BITWIDTH/DIGIT combination");
      end
   endgenerate

   localparam int N     = BITWIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int PP_W  = BITWIDTH + DIGIT;
   localparam int Y_W   = 2 * BITWIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [BITWIDTH-1:0] a_r;
   logic [BITWIDTH-1:0] b_r;
   logic [Y_W-1:0]      acc;
   logic [CNT_W-1:0]    cnt;

   logic [PP_W-1:0]     pp;
   logic [31:0]         shamt;
   logic [Y_W-1:0]      acc_next;
   logic [BITWIDTH-1:0] b_load;

   always_comb begin
      pp       = PP_W'(a_r) * PP_W'(b_r[DIGIT-1:0]);
      shamt    = 32'(cnt) * 32'(DIGIT);
      acc_next = acc + (Y_W'(pp) << shamt);
`ifdef SEQ_MULT_SQUARE_EN
      b_load   = square ? a : b;
`else
      b_load   = b;
`endif
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         cnt   <= '0;
         y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b_load;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_next;
               b_r <= b_r >> DIGIT;
               cnt <= cnt + CNT_W'(1);
               // y is taken from the combinational sum so it is final on the same edge
               if (cnt == CNT_W'(N - 1)) begin
                  y     <= acc_next;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle, parametrised unsigned integer multiplier with valid/ready handshakes on input and output. It replaces the single-cycle combinational adder-tree multiplier wherever area matters more than latency, starting with the Barrett reduction datapath. It consumes `DIGIT` bits of the multiplier operand per clock. The full `2*BITWIDTH`-bit product is held in an output register until the consumer accepts it.

## Interface
- `BITWIDTH`, default 32: operand width in bits. Must be ≥ 1.
- `DIGIT`, default 4: multiplier bits retired per cycle.
  - Must satisfy 1 ≤ `DIGIT` ≤ `BITWIDTH` and `BITWIDTH % DIGIT == 0`.
  - Elaboration fails otherwise.
  - N = `BITWIDTH/DIGIT` compute cycles per operation.

Ports:
- `sys_clk`  in  1: single clock, rising edge.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands `a`/`b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  `BITWIDTH`: multiplicand.
- `b`  in  `BITWIDTH`: multiplier.
- `square`  in  1: only present when `SEQ_MULT_SQUARE_EN` is defined; see Configuration.
- `out_valid`  out  1: `y` holds a completed product.
- `out_ready`  in  1: consumer accepts `y`.
- `y`  out  `2*BITWIDTH`: unsigned product `a*b`.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. The state is registered; reset forces IDLE.
- `in_ready` = (state == IDLE), decoded directly from the state register.
- `out_valid` = (state == DONE).
- IDLE:
  - An accept occurs on an edge where `in_valid && in_ready`.
  - On accept, latch `a` into `a_r` and `b` into `b_r`, clear `acc` (`2*BITWIDTH` bits), clear `cnt`, and go to BUSY.
  - Operands are sampled only on the accept edge; later changes on `a`/`b` have no effect.
- BUSY, on each edge:
  - `acc += (a_r * b_r[DIGIT-1:0]) << (DIGIT*cnt)`.
  - `b_r >>= DIGIT`.
  - `cnt += 1`.
  - On the edge where `cnt == N-1`, write the final sum into `y` and go to DONE.
  - `in_valid` is ignored throughout BUSY.
- Arithmetic:
  - Unsigned and exact.
  - Each `DIGIT`×`BITWIDTH` partial product is `BITWIDTH+DIGIT` bits wide.
  - `acc` never overflows `2*BITWIDTH` bits.
  - `cnt` width is `max(1, $clog2(N))`.
- DONE:
  - Hold `y` stable.
  - On an edge with `out_ready` high, go to IDLE.
  - The block does not accept new operands on the same edge as the output handshake.
- `y` updates only on the BUSY→DONE edge. It otherwise keeps the last completed product.
- Reset:
  - While `sys_rst_n` is low, outputs are `in_ready`=1, `out_valid`=0, `y`=0, and `acc`/`cnt`/`a_r`/`b_r` are 0.
  - Reset asserted during BUSY or DONE aborts the operation. The product is discarded and no `out_valid` pulse follows.

## Timing
- Accept edge t0: BUSY is entered and `in_ready` drops after t0.
- BUSY edges t1…tN. On edge tN the state enters DONE; `out_valid`=1 and `y` is valid from after tN.
  - Latency from the accept edge to `out_valid` is N cycles.
- Output handshake edge tD (tD ≥ N): the state returns to IDLE, with `out_valid`=0 and `in_ready`=1 after tD.
- Minimum issue interval is N+2 cycles, with `out_ready` tied high.
- `DIGIT == BITWIDTH`: N=1, giving a one-cycle compute and a 3-cycle minimum interval.
- `out_ready` asserted while not in DONE has no effect.

## Configuration
- `SEQ_MULT_SQUARE_EN`:
  - Defined:
    - The `square` input exists and is sampled on the accept edge.
    - If `square`=1, `b_r` is loaded from `a` and port `b` is ignored, so `y` = `a*a`. This serves modular-squaring chains.
    - Latency and handshake are unchanged.
  - Undefined: the `square` port is absent and `b_r` always loads from `b`.

## Test plan
- Reset, then release → `in_ready`=1, `out_valid`=0, `y`=0. Hold `out_ready`=1 for 20 cycles with `in_valid`=0 → no state change.
- `BITWIDTH`=32, `DIGIT`=4, `a`=`b`=0xFFFFFFFF → `out_valid` rises exactly 8 cycles after the accept edge, with `y`=0xFFFFFFFE00000001.
- Backpressure: `a`=3, `b`=5, `out_ready`=0 for 6 cycles after `out_valid`.
  - Expect `y`=15 stable, `in_ready`=0, and a concurrent `in_valid` with `a`=7 ignored.
  - After `out_ready` goes high, `in_ready`=1 one cycle later.
- Pull `sys_rst_n` low on the 3rd BUSY cycle of `a`=0x1234, `b`=0x5678 → immediate IDLE, `y`=0, and `out_valid` never asserts.
- `SEQ_MULT_SQUARE_EN` defined, `square`=1, `a`=0x00010001, `b`=0xDEADBEEF → `y`=0x0000000100020001.
- Random regression, 1000 ops each at `DIGIT`=1, 4 and 32, with random `in_valid`/`out_ready` gaps:
  - Every `y` must equal the golden `a*b`.
  - Product count must equal accept count.
  - Latency must be exactly N.
